// File: rtl/mc_rsp_pkg.sv
// Shared widths and the response-entry type for the vadd memory-controller responder.
// Imported by mc_rsp_fifo and mc_rsp_model.
package mc_rsp_pkg;

   localparam int MC_RDCTL_W = 32;
   localparam int MC_DATA_W  = 64;
   localparam int MC_VADR_W  = 48;

   typedef struct packed {
      logic [MC_RDCTL_W-1:0] rdctl;
      logic [MC_DATA_W-1:0]  data;
   } rsp_ent_t;

endpackage

// File: rtl/mc_rsp_fifo.sv
// Synchronous FIFO of load responses with occupancy count.
// Writes while full are ignored unless a read happens in the same cycle.
module mc_rsp_fifo
   import mc_rsp_pkg::*;
#(
   parameter int DEPTH = 16
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic                     wr_en,
   input  rsp_ent_t                 wr_data,
   input  logic                     rd_en,
   output rsp_ent_t                 rd_data,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     full,
   output logic                     empty
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   rsp_ent_t        mem [DEPTH];
   logic [PW-1:0]   wr_ptr;
   logic [PW-1:0]   rd_ptr;
   logic            do_wr;
   logic            do_rd;

   assign empty = (count == '0);
   assign full  = (count == CW'(DEPTH));
   assign do_rd = rd_en && !empty;
   assign do_wr = wr_en && (!full || do_rd);

   // NOTE: non-blocking assignments for all state, so every register sees pre-edge values.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_wr) wr_ptr <= wr_ptr + PW'(1);
         if (do_rd) rd_ptr <= rd_ptr + PW'(1);
         if (do_wr && !do_rd)      count <= count + CW'(1);
         else if (do_rd && !do_wr) count <= count - CW'(1);
      end
   end

   // NOTE: storage is not reset; the cleared pointers and count make stale entries unreachable.
   always_ff @(posedge clk) begin
      if (do_wr) mem[wr_ptr] <= wr_data;
   end

   assign rd_data = mem[rd_ptr];

endmodule

// File: rtl/mc_rsp_model.sv
// Memory-controller responder for one vadd port: word memory, LAT-cycle load pipe, response FIFO.
// Define MC_RSP_STATS_EN to add the ld_cnt/st_cnt/stall_cyc statistics outputs.
module mc_rsp_model
   import mc_rsp_pkg::*;
#(
   parameter int AW           = 10,
   parameter int LAT          = 4,
   parameter int DEPTH        = 16,
   parameter int STALL_MARGIN = 4
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  mc_req_ld,
   input  logic                  mc_req_st,
   input  logic [MC_DATA_W-1:0]  mc_req_wrd_rdctl,
   input  logic [MC_VADR_W-1:0]  mc_req_vadr,
   input  logic                  mc_rsp_stall,
   input  logic                  inj_rd_stall,
   input  logic                  inj_wr_stall,
   output logic                  mc_rd_rq_stall,
   output logic                  mc_wr_rq_stall,
   output logic                  mc_rsp_push,
   output logic [MC_RDCTL_W-1:0] mc_rsp_rdctl,
   output logic [MC_DATA_W-1:0]  mc_rsp_data,
   output logic                  req_err,
   output logic                  rsp_ovf
`ifdef MC_RSP_STATS_EN
   ,
   output logic [31:0]           ld_cnt,
   output logic [31:0]           st_cnt,
   output logic [31:0]           stall_cyc
`endif
);

   localparam int CW = $clog2(DEPTH) + 1;
   localparam int IW = $clog2(LAT) + 1;
   localparam int OW = $clog2(DEPTH + LAT) + 1;

   logic [MC_DATA_W-1:0] mem [2**AW];
   logic [AW-1:0]        idx;
   logic                 ld_ok;
   logic                 st_ok;
   logic                 req_bad;
   logic                 unused_vadr_hi;
   rsp_ent_t             ld_ent;

   // High address bits alias onto the same word; the low three only flag misalignment.
   assign idx            = mc_req_vadr[AW+2:3];
   assign unused_vadr_hi = ^mc_req_vadr[MC_VADR_W-1:AW+3];

   assign ld_ok   = mc_req_ld && !mc_req_st;
   assign st_ok   = mc_req_st && !mc_req_ld;
   assign req_bad = (mc_req_ld && mc_req_st) ||
                    ((mc_req_ld || mc_req_st) && (mc_req_vadr[2:0] != 3'b000));

   always_ff @(posedge clk) begin
      if (reset_n && st_ok) mem[idx] <= mc_req_wrd_rdctl;
   end

   // Asynchronous read, so a load the cycle after a store already sees the new word.
   assign ld_ent = '{rdctl: mc_req_wrd_rdctl[MC_RDCTL_W-1:0], data: mem[idx]};

   logic            dl_vld;
   rsp_ent_t        dl_ent;
   logic [IW-1:0]   inflight;

   if (LAT > 1) begin : g_dl
      logic [LAT-2:0] vld;
      rsp_ent_t       ent [LAT-1];

      always_ff @(posedge clk) begin
         if (!reset_n) begin
            vld <= '0;
         end else begin
            vld[0] <= ld_ok;
            for (int i = 1; i < LAT-1; i++) vld[i] <= vld[i-1];
         end
      end

      always_ff @(posedge clk) begin
         ent[0] <= ld_ent;
         for (int i = 1; i < LAT-1; i++) ent[i] <= ent[i-1];
      end

      // NOTE: default assigned first so no path through the block can infer a latch.
      always_comb begin
         inflight = '0;
         for (int i = 0; i < LAT-1; i++) inflight = inflight + IW'(vld[i]);
      end

      assign dl_vld = vld[LAT-2];
      assign dl_ent = ent[LAT-2];
   end else begin : g_nodl
      assign dl_vld   = ld_ok;
      assign dl_ent   = ld_ent;
      assign inflight = '0;
   end

   rsp_ent_t        rd_ent;
   logic [CW-1:0]   fifo_cnt;
   logic            fifo_full;
   logic            fifo_empty;
   logic            pop;
   logic            drop;
   logic [OW-1:0]   occ;

   assign pop  = !fifo_empty && !mc_rsp_stall;
   // A full FIFO still takes the entry when it pops in the same cycle.
   assign drop = dl_vld && fifo_full && !pop;
   assign occ  = OW'(fifo_cnt) + OW'(inflight);

   mc_rsp_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .reset_n (reset_n),
      .wr_en   (dl_vld),
      .wr_data (dl_ent),
      .rd_en   (pop),
      .rd_data (rd_ent),
      .count   (fifo_cnt),
      .full    (fifo_full),
      .empty   (fifo_empty)
   );

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         mc_rsp_push    <= 1'b0;
         mc_rsp_rdctl   <= '0;
         mc_rsp_data    <= '0;
         mc_rd_rq_stall <= 1'b0;
         mc_wr_rq_stall <= 1'b0;
         req_err        <= 1'b0;
         rsp_ovf        <= 1'b0;
      end else begin
         mc_rsp_push <= pop;
         if (pop) begin
            mc_rsp_rdctl <= rd_ent.rdctl;
            mc_rsp_data  <= rd_ent.data;
         end
         // Margin leaves room for loads already on the way while the requester reacts.
         mc_rd_rq_stall <= inj_rd_stall || (occ >= OW'(DEPTH - STALL_MARGIN));
         mc_wr_rq_stall <= inj_wr_stall;
         if (req_bad) req_err <= 1'b1;
         if (drop)    rsp_ovf <= 1'b1;
      end
   end

`ifdef MC_RSP_STATS_EN
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         ld_cnt    <= '0;
         st_cnt    <= '0;
         stall_cyc <= '0;
      end else begin
         if (ld_ok) ld_cnt <= ld_cnt + 32'd1;
         if (st_ok) st_cnt <= st_cnt + 32'd1;
         if (mc_rsp_stall && !fifo_empty) stall_cyc <= stall_cyc + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_mc_rsp_model.sv
// Self-checking bench for mc_rsp_model: directed scenarios plus random traffic,
// all compared every cycle against a queue-based reference model.
module tb_mc_rsp_model;
   import mc_rsp_pkg::*;

   localparam int AW     = 10;
   localparam int LAT    = 4;
   localparam int DEPTH  = 16;
   localparam int MARGIN = 4;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        mc_req_ld = 1'b0;
   logic        mc_req_st = 1'b0;
   logic [63:0] wrd = '0;
   logic [47:0] vadr = '0;
   logic        rsp_stall = 1'b0;
   logic        inj_rd = 1'b0;
   logic        inj_wr = 1'b0;

   logic        mc_rd_rq_stall;
   logic        mc_wr_rq_stall;
   logic        mc_rsp_push;
   logic [31:0] mc_rsp_rdctl;
   logic [63:0] mc_rsp_data;
   logic        req_err;
   logic        rsp_ovf;
`ifdef MC_RSP_STATS_EN
   logic [31:0] ld_cnt;
   logic [31:0] st_cnt;
   logic [31:0] stall_cyc;
`endif

   mc_rsp_model #(
      .AW           (AW),
      .LAT          (LAT),
      .DEPTH        (DEPTH),
      .STALL_MARGIN (MARGIN)
   ) dut (
      .clk              (clk),
      .reset_n          (reset_n),
      .mc_req_ld        (mc_req_ld),
      .mc_req_st        (mc_req_st),
      .mc_req_wrd_rdctl (wrd),
      .mc_req_vadr      (vadr),
      .mc_rsp_stall     (rsp_stall),
      .inj_rd_stall     (inj_rd),
      .inj_wr_stall     (inj_wr),
      .mc_rd_rq_stall   (mc_rd_rq_stall),
      .mc_wr_rq_stall   (mc_wr_rq_stall),
      .mc_rsp_push      (mc_rsp_push),
      .mc_rsp_rdctl     (mc_rsp_rdctl),
      .mc_rsp_data      (mc_rsp_data),
      .req_err          (req_err),
      .rsp_ovf          (rsp_ovf)
`ifdef MC_RSP_STATS_EN
      ,
      .ld_cnt           (ld_cnt),
      .st_cnt           (st_cnt),
      .stall_cyc        (stall_cyc)
`endif
   );

   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_fail = 0;
   int cyc    = 0;

   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (edge %0d)", tag, act, exp, cyc);
      end
   endtask

   // Reference model: loads become visible in the response queue LAT-1 edges after accept,
   // the queue holds DEPTH entries, and one entry leaves per unstalled edge.
   typedef struct packed {
      logic [31:0] rdctl;
      logic [63:0] data;
   } ent_t;

   ent_t        m_fifo[$];
   ent_t        p_ent[$];
   int          p_arr[$];
   logic [63:0] m_mem [1024];

   logic        e_push, e_rd, e_wr, e_err, e_ovf;
   logic [31:0] e_rdctl;
   logic [63:0] e_data;
   int unsigned e_ld, e_st, e_sc;

   task automatic model_step();
      int   occ;
      int   idx;
      ent_t e;
      if (!reset_n) begin
         m_fifo.delete();
         p_ent.delete();
         p_arr.delete();
         e_push = 0; e_rd = 0; e_wr = 0; e_err = 0; e_ovf = 0;
         e_rdctl = '0; e_data = '0;
         e_ld = 0; e_st = 0; e_sc = 0;
         return;
      end
      occ  = m_fifo.size() + p_ent.size();
      e_rd = inj_rd || (occ >= DEPTH - MARGIN);
      e_wr = inj_wr;
      if (rsp_stall && m_fifo.size() != 0) e_sc++;
      e_push = 0;
      if (m_fifo.size() != 0 && !rsp_stall) begin
         e       = m_fifo.pop_front();
         e_push  = 1;
         e_rdctl = e.rdctl;
         e_data  = e.data;
      end
      idx = int'(vadr[AW+2:3]);
      if (mc_req_ld && mc_req_st) begin
         e_err = 1;
      end else if (mc_req_ld || mc_req_st) begin
         if (vadr[2:0] != 3'b000) e_err = 1;
         if (mc_req_st) begin
            m_mem[idx] = wrd;
            e_st++;
         end else begin
            e.rdctl = wrd[31:0];
            e.data  = m_mem[idx];
            p_ent.push_back(e);
            p_arr.push_back(cyc + LAT - 1);
            e_ld++;
         end
      end
      if (p_ent.size() != 0 && p_arr[0] == cyc) begin
         e = p_ent.pop_front();
         void'(p_arr.pop_front());
         if (m_fifo.size() < DEPTH) m_fifo.push_back(e);
         else e_ovf = 1;
      end
   endtask

   task automatic cycle();
      @(posedge clk);
      cyc++;
      model_step();
      #1;
      check("push", mc_rsp_push, e_push);
      if (e_push) begin
         check("rdctl", mc_rsp_rdctl, e_rdctl);
         check("data", mc_rsp_data, e_data);
      end
      check("rd_stall", mc_rd_rq_stall, e_rd);
      check("wr_stall", mc_wr_rq_stall, e_wr);
      check("req_err", req_err, e_err);
      check("rsp_ovf", rsp_ovf, e_ovf);
`ifdef MC_RSP_STATS_EN
      check("ld_cnt", ld_cnt, e_ld);
      check("st_cnt", st_cnt, e_st);
      check("stall_cyc", stall_cyc, e_sc);
`endif
   endtask

   function automatic logic [47:0] mk(input int idx, input bit alias_hi, input logic [2:0] lo);
      logic [47:0] v;
      v       = alias_hi ? {16'($urandom), 32'($urandom)} : 48'd0;
      v[12:3] = 10'(idx);
      v[2:0]  = lo;
      return v;
   endfunction

   task automatic req(input logic ld, input logic st, input logic [47:0] a, input logic [63:0] d);
      mc_req_ld = ld;
      mc_req_st = st;
      vadr      = a;
      wrd       = d;
      cycle();
   endtask

   task automatic idle(input int n);
      mc_req_ld = 1'b0;
      mc_req_st = 1'b0;
      repeat (n) cycle();
   endtask

   task automatic do_reset();
      mc_req_ld = 1'b0;
      mc_req_st = 1'b0;
      reset_n   = 1'b0;
      cycle();
      reset_n   = 1'b1;
   endtask

   task automatic wait_push(input int budget, output int edges);
      int start;
      start     = cyc;
      mc_req_ld = 1'b0;
      mc_req_st = 1'b0;
      while (!mc_rsp_push && (cyc - start) < budget) cycle();
      edges = cyc - start;
      check("push_seen", mc_rsp_push, 1);
   endtask

   initial begin
      int          lat;
      int          n;
      int          r;
      logic [63:0] d2;

      do_reset();
      check("rst_push", mc_rsp_push, 0);
      check("rst_rdctl", mc_rsp_rdctl, 0);
      check("rst_data", mc_rsp_data, 0);
      check("rst_rd_stall", mc_rd_rq_stall, 0);
      check("rst_err", req_err, 0);

      // Store then load at 0x40: exact latency, data and tag.
      req(0, 1, mk(8, 0, 3'b000), 64'h1111_2222_3333_4444);
      req(1, 0, mk(8, 0, 3'b000), 64'h0000_ABCD);
      wait_push(12, lat);
      check("ld1_lat", lat, LAT);
      check("ld1_data", mc_rsp_data, 64'h1111_2222_3333_4444);
      check("ld1_tag", mc_rsp_rdctl, 32'h0000_ABCD);

      // Load the cycle right after a store to the same word.
      d2 = {$urandom, $urandom};
      req(0, 1, mk(16, 0, 3'b000), d2);
      req(1, 0, mk(16, 0, 3'b000), 64'h77);
      wait_push(12, lat);
      check("raw_data", mc_rsp_data, d2);
      check("raw_tag", mc_rsp_rdctl, 32'h77);
      idle(2);

      // Fill the words the random phase loads from.
      for (int i = 0; i < 32; i++) req(0, 1, mk(i, 1, 3'b000), {$urandom, $urandom});

      for (int k = 0; k < 1500; k++) begin
         rsp_stall = ($urandom_range(0, 99) < 35);
         inj_rd    = ($urandom_range(0, 99) < 10);
         inj_wr    = ($urandom_range(0, 99) < 10);
         r         = $urandom_range(0, 99);
         if (r < 40)      req(1, 0, mk($urandom_range(0, 31), 1, 3'b000), {$urandom, $urandom});
         else if (r < 60) req(0, 1, mk($urandom_range(0, 31), 1, 3'b000), {$urandom, $urandom});
         else if (r < 62) req(1, 1, mk($urandom_range(0, 31), 1, 3'b000), {$urandom, $urandom});
         else             idle(1);
      end
      rsp_stall = 1'b0;
      inj_rd    = 1'b0;
      inj_wr    = 1'b0;
      idle(30);
      do_reset();

      // 16 back-to-back loads under response stall: stall threshold, order, no overflow.
      rsp_stall = 1'b1;
      for (int i = 0; i < 16; i++) req(1, 0, mk(i, 0, 3'b000), 64'(i));
      idle(LAT);
      check("stall_hi", mc_rd_rq_stall, 1);
      rsp_stall = 1'b0;
      n = 0;
      for (int k = 0; k < 40; k++) begin
         idle(1);
         if (mc_rsp_push) begin
            check("order", mc_rsp_rdctl, 32'(n));
            n++;
         end
      end
      check("n_push16", n, 16);
      check("no_ovf", rsp_ovf, 0);
      check("stall_lo", mc_rd_rq_stall, 0);

      // 17 loads with the requester stalled: the last one cannot fit.
      rsp_stall = 1'b1;
      for (int i = 0; i < 17; i++) req(1, 0, mk(i, 0, 3'b000), 64'(100 + i));
      idle(LAT);
      check("ovf_set", rsp_ovf, 1);
      rsp_stall = 1'b0;
      idle(30);

      // Load and store together: ignored, error flagged, memory unchanged.
      check("err_pre", req_err, 0);
      req(1, 1, mk(3, 0, 3'b000), 64'hDEAD_BEEF_DEAD_BEEF);
      idle(LAT + 2);
      check("err_set", req_err, 1);
      req(1, 0, mk(3, 0, 3'b000), 64'h33);
      wait_push(12, lat);
      check("err_mem", mc_rsp_data, m_mem[3]);
      check("err_sticky", req_err, 1);

      // Reset with three loads in flight discards them.
      for (int i = 0; i < 3; i++) req(1, 0, mk(i + 4, 0, 3'b000), 64'(200 + i));
      do_reset();
      check("rst2_push", mc_rsp_push, 0);
      check("rst2_err", req_err, 0);
      check("rst2_ovf", rsp_ovf, 0);
      check("rst2_data", mc_rsp_data, 0);
      n = 0;
      for (int k = 0; k < 10; k++) begin
         idle(1);
         if (mc_rsp_push) n++;
      end
      check("rst2_nopush", n, 0);

      // Misaligned load still executes and flags the error.
      req(1, 0, mk(5, 1, 3'b100), 64'h55);
      wait_push(12, lat);
      check("mis_data", mc_rsp_data, m_mem[5]);
      check("mis_err", req_err, 1);
      idle(4);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
